// File: rtl/xchg_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// xchg_sequencer_pkg
//   Shared Mk1 definitions for the exchange sequencer: default datapath
//   widths, the XCHG opcode and the sequencer state encoding.
//   No ports; imported by xchg_sequencer.
// ---------------------------------------------------------------------------
package xchg_sequencer_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ADDR_W_DEF = 3;

  // XCHG Ra,Rb opcode as decoded by the Mk1 control unit.
  localparam logic [7:0] XCHG_OPCODE = 8'h2C;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    WR_A = 3'd2,
    WR_B = 3'd3,
    DONE = 3'd4
  } xchgState_t;

endpackage

// File: rtl/xchg_sequencer.sv
// ---------------------------------------------------------------------------
// xchg_sequencer
//   Executes XCHG Ra,Rb against a single-write-port register file: both
//   registers are read in one cycle, written back swapped over two cycles,
//   then a one-cycle done pulse is raised. If Ra and Rb name the same
//   register both writes are skipped.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start               exchange request, only looked at in IDLE
//   ra_addr, rb_addr    register indices, latched with start
//   busy                high in every state except IDLE
//   done                one-cycle completion pulse
//   rf_raddr0/1         register-file read addresses (latched ra/rb)
//   rf_rdata0/1         combinational register-file read data
//   rf_we, rf_waddr,
//   rf_wdata            register-file write port
//   A, B                captured pre-swap values of Ra and Rb
// ---------------------------------------------------------------------------
module xchg_sequencer
  import xchg_sequencer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rf_raddr0,
  output logic [ADDR_W-1:0] rf_raddr1,
  input  logic [DATA_W-1:0] rf_rdata0,
  input  logic [DATA_W-1:0] rf_rdata1,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B
);

  xchgState_t        state;
  logic [ADDR_W-1:0] raLat;
  logic [ADDR_W-1:0] rbLat;

  // The latched operand addresses drive the read ports directly.
  assign rf_raddr0 = raLat;
  assign rf_raddr1 = rbLat;

  // Sequencer FSM; every output is set up one edge ahead so it is a flop
  // that matches the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      raLat    <= {ADDR_W{1'b0}};
      rbLat    <= {ADDR_W{1'b0}};
      busy     <= 1'b0;
      done     <= 1'b0;
      rf_we    <= 1'b0;
      rf_waddr <= {ADDR_W{1'b0}};
      rf_wdata <= {DATA_W{1'b0}};
      A        <= {DATA_W{1'b0}};
      B        <= {DATA_W{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          done  <= 1'b0;
          rf_we <= 1'b0;
          if (start) begin
            raLat <= ra_addr;
            rbLat <= rb_addr;
            busy  <= 1'b1;
            state <= READ;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        READ: begin
          A <= rf_rdata0;
          B <= rf_rdata1;
          if (raLat == rbLat) begin
            // Swapping a register with itself is a no-op on the file.
            done  <= 1'b1;
            state <= DONE;
          end else begin
            // First write takes the freshly read Rb value, not the B flop,
            // since B only updates on this same edge.
            rf_we    <= 1'b1;
            rf_waddr <= raLat;
            rf_wdata <= rf_rdata1;
            state    <= WR_A;
          end
        end
        WR_A: begin
          rf_we    <= 1'b1;
          rf_waddr <= rbLat;
          rf_wdata <= A;
          state    <= WR_B;
        end
        WR_B: begin
          rf_we <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          rf_we <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          rf_we <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xchg_sequencer.sv
// ---------------------------------------------------------------------------
// tb_xchg_sequencer
//   Directed plus randomized bench for xchg_sequencer. The bench owns a
//   simple 8x16 register file, and a reference array holds the register
//   contents an exchange is supposed to produce.
// ---------------------------------------------------------------------------
module tb_xchg_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  ra_addr;
  logic [2:0]  rb_addr;
  logic        busy;
  logic        done;
  logic [2:0]  rf_raddr0;
  logic [2:0]  rf_raddr1;
  logic [15:0] rf_rdata0;
  logic [15:0] rf_rdata1;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic [15:0] A;
  logic [15:0] B;

  logic [15:0] rf  [8];
  logic [15:0] mem [8];
  logic        tbWe;
  logic [2:0]  tbWaddr;
  logic [15:0] tbWdata;

  int nAsserts = 0;
  int nFail    = 0;

  always #5 clk = ~clk;

  xchg_sequencer #(.DATA_W(16), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .ra_addr(ra_addr), .rb_addr(rb_addr),
    .busy(busy), .done(done), .rf_raddr0(rf_raddr0), .rf_raddr1(rf_raddr1),
    .rf_rdata0(rf_rdata0), .rf_rdata1(rf_rdata1), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .A(A), .B(B)
  );

  // Register file: DUT write port, plus a bench port for preloading.
  always @(posedge clk) begin
    if (rf_we) rf[rf_waddr] <= rf_wdata;
    else if (tbWe) rf[tbWaddr] <= tbWdata;
  end
  assign rf_rdata0 = rf[rf_raddr0];
  assign rf_rdata1 = rf[rf_raddr1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic loadReg(input logic [2:0] a, input logic [15:0] v);
    tbWe = 1'b1; tbWaddr = a; tbWdata = v;
    @(negedge clk);
    tbWe = 1'b0;
    mem[a] = v;
  endtask

  task automatic checkRf(input string tag);
    for (int i = 0; i < 8; i++) chk($sformatf("%s_r%0d", tag, i), rf[i], mem[i]);
  endtask

  // One exchange, entered and left on a negedge in IDLE. Expected timing:
  // done seen 4 cycles after the start edge, or 2 when ra==rb; writes are
  // (ra <= old Rb) then (rb <= old Ra), none when ra==rb.
  task automatic runXchg(input logic [2:0] ra, input logic [2:0] rb, input bit busyPoke);
    logic [15:0] oldA, oldB;
    logic [2:0]  wAddr [2];
    logic [15:0] wData [2];
    int doneAt, nWr, expDone, extraDone, extraBusy;
    oldA = mem[ra]; oldB = mem[rb];
    expDone = (ra == rb) ? 2 : 4;
    doneAt = 0; nWr = 0; extraDone = 0; extraBusy = 0;
    wAddr[0] = 3'd0; wAddr[1] = 3'd0; wData[0] = 16'd0; wData[1] = 16'd0;
    start = 1'b1; ra_addr = ra; rb_addr = rb;
    @(negedge clk);
    start = 1'b0; ra_addr = 3'($urandom); rb_addr = 3'($urandom);
    for (int k = 1; k <= 8; k++) begin
      if (k == 1) begin
        chk("busy_read", busy, 1);
        chk("raddr0", rf_raddr0, ra);
        chk("raddr1", rf_raddr1, rb);
      end
      if (k == 2) begin
        chk("A_capt", A, oldA);
        chk("B_capt", B, oldB);
      end
      if (rf_we) begin
        if (nWr < 2) begin wAddr[nWr] = rf_waddr; wData[nWr] = rf_wdata; end
        nWr++;
      end
      if (busyPoke && k == 2) begin
        start = 1'b1; ra_addr = 3'd3; rb_addr = 3'd4;
      end else begin
        start = 1'b0;
      end
      if (done) begin doneAt = k; break; end
      @(negedge clk);
    end
    start = 1'b0;
    chk("done_latency", doneAt, expDone);
    chk("write_count", nWr, (ra == rb) ? 0 : 2);
    if (ra != rb) begin
      chk("wr0_addr", wAddr[0], ra);
      chk("wr0_data", wData[0], oldB);
      chk("wr1_addr", wAddr[1], rb);
      chk("wr1_data", wData[1], oldA);
    end
    mem[ra] = oldB;
    mem[rb] = oldA;
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("busy_after", busy, 0);
    chk("A_hold", A, oldA);
    chk("B_hold", B, oldB);
    if (busyPoke) begin
      // An ignored start must not resurface as a second exchange.
      repeat (6) begin
        @(negedge clk);
        if (done) extraDone++;
        if (busy) extraBusy++;
      end
      chk("poke_no_done", extraDone, 0);
      chk("poke_no_busy", extraBusy, 0);
    end
    checkRf("rf");
  endtask

  initial begin
    int stuck;
    logic [2:0] ra, rb;
    rst = 1'b1; start = 1'b0; ra_addr = 3'd0; rb_addr = 3'd0;
    tbWe = 1'b0; tbWaddr = 3'd0; tbWdata = 16'd0;
    repeat (3) @(negedge clk);

    // Reset state.
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_we", rf_we, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_raddr0", rf_raddr0, 0);
    chk("rst_raddr1", rf_raddr1, 0);
    chk("rst_A", A, 0);
    chk("rst_B", B, 0);

    // start together with rst is dropped.
    start = 1'b1; ra_addr = 3'd1; rb_addr = 3'd2;
    @(negedge clk);
    chk("rst_start_busy", busy, 0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_start_dropped", busy, 0);

    // Preload the register file.
    loadReg(3'd0, 16'hFFFF);
    loadReg(3'd1, 16'd99);
    loadReg(3'd2, 16'd64);
    loadReg(3'd3, 16'($urandom));
    loadReg(3'd4, 16'($urandom));
    loadReg(3'd5, 16'h1234);
    loadReg(3'd6, 16'($urandom));
    loadReg(3'd7, 16'h0000);
    checkRf("preload");

    // Basic swap, then back-to-back on the same pair restores it.
    runXchg(3'd1, 3'd2, 1'b0);
    chk("basic_r1", rf[1], 16'd64);
    chk("basic_r2", rf[2], 16'd99);
    runXchg(3'd1, 3'd2, 1'b0);
    chk("b2b_r1", rf[1], 16'd99);
    chk("b2b_r2", rf[2], 16'd64);

    // Same register: no writes, short latency.
    runXchg(3'd5, 3'd5, 1'b0);
    chk("same_r5", rf[5], 16'h1234);

    // All-ones / all-zeros.
    runXchg(3'd0, 3'd7, 1'b0);
    chk("ext_r0", rf[0], 16'h0000);
    chk("ext_r7", rf[7], 16'hFFFF);

    // A start issued in WR_A is ignored.
    runXchg(3'd1, 3'd2, 1'b1);

    // Reset lands on the edge that would take the sequencer into WR_B:
    // the Ra write has happened, the Rb write never does.
    start = 1'b1; ra_addr = 3'd1; rb_addr = 3'd2;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("pre_rst_we", rf_we, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_we", rf_we, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_A", A, 0);
    mem[1] = mem[2];
    stuck = 0;
    repeat (5) begin
      @(negedge clk);
      if (done || busy || rf_we) stuck++;
    end
    chk("midrst_quiet", stuck, 0);
    checkRf("midrst");

    // Randomized exchanges against the reference array.
    for (int i = 0; i < 10; i++) begin
      ra = 3'($urandom_range(0, 7));
      rb = (i % 4 == 0) ? ra : 3'($urandom_range(0, 7));
      loadReg(ra, 16'($urandom));
      loadReg(rb, 16'($urandom));
      runXchg(ra, rb, (i % 5 == 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
